// File: rtl/rf_phoenix_trace_buffer_pkg.sv
// Shared types and constants for the rfPhoenix branch-trace capture path.
package rfPhoenixPkg;

  localparam int TRACE_DEPTH = 1024;

  typedef logic [31:0] Address;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

endpackage

// File: rtl/rf_phoenix_trace_ram.sv
// Simple dual-port trace RAM: synchronous read-first read port, one write port.
module rf_phoenix_trace_ram #(
  parameter int DEPTH = 1024,
  parameter int AWID  = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [PW-1:0]   waddr,
  input  logic [AWID-1:0] wdata,
  input  logic            re,
  input  logic [PW-1:0]   raddr,
  output logic [AWID-1:0] rdata
);

  logic [AWID-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when no read is issued; a same-address write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rf_phoenix_trace_buffer.sv
// Branch-trace capture FIFO with arm/trigger/freeze control; producer side of the trace interface.
module rf_phoenix_trace_buffer
  import rfPhoenixPkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int AWID  = 32,
  parameter int CWID  = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_en,
  input  logic            cfg_wrap,
  input  logic            cfg_trig_en,
  input  logic [AWID-1:0] cfg_trig_adr,
  input  logic            clr,
  input  logic            commit_v,
  input  logic            commit_taken,
  input  logic [AWID-1:0] commit_pc,
  input  logic [AWID-1:0] commit_tgt,
  input  logic            pop,
  output logic [AWID-1:0] trace_dout,
  output logic            trace_valid,
  output logic            trace_empty,
  output logic [CWID-1:0] trace_count,
  output logic            trace_ovf,
  output logic [1:0]      trace_state
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CWID-1:0] FULL_CNT = CWID'(DEPTH);

  trace_state_t    state, state_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CWID-1:0] count;
  logic            ovf;
  logic            full, empty, trig_hit, push_req, pop_ok, push_wr, drop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign trig_hit = (state == ARMED) && commit_v && (commit_pc == cfg_trig_adr);
  assign push_req = commit_v && commit_taken && ((state == RECORD) || trig_hit);
  assign pop_ok   = pop && !empty && !clr;
  assign push_wr  = push_req && !clr && (!full || cfg_wrap);
  assign drop     = push_req && !clr && full && !cfg_wrap;

  always_comb begin
    state_nxt = state;
    if (clr || !cfg_en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = cfg_trig_en ? ARMED : RECORD;
        ARMED:   if (trig_hit) state_nxt = drop ? FROZEN : RECORD;
        RECORD:  if (drop) state_nxt = FROZEN;
        FROZEN:  state_nxt = FROZEN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      trace_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      trace_valid <= pop_ok;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push_wr) wr_ptr <= wr_ptr + 1'b1;
        // A wrapping push at full overwrites the oldest entry, so the read side skips past it.
        if (pop_ok || (push_wr && full)) rd_ptr <= rd_ptr + 1'b1;
        if (push_req && full) ovf <= 1'b1;
        if (push_wr && !full && !pop_ok)  count <= count + 1'b1;
        else if (pop_ok && !push_wr)      count <= count - 1'b1;
      end
    end
  end

  rf_phoenix_trace_ram #(
    .DEPTH (DEPTH),
    .AWID  (AWID),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_wr),
    .waddr (wr_ptr),
    .wdata (commit_tgt),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (trace_dout)
  );

  assign trace_empty = empty;
  assign trace_count = count;
  assign trace_ovf   = ovf;
  assign trace_state = state;

endmodule

// File: doc/rf_phoenix_trace_buffer.md
Name: rf_phoenix_trace_buffer

Overview:
- Branch-trace capture FIFO: records the target address of every taken branch at commit.
- Serves as the producer end of the trace interface (trace_dout/trace_empty/trace_valid/trace_count) that the vector ALU consumes when a trace-read instruction executes.
- Contains a small arm/trigger/freeze state machine and a read-first circular buffer with selectable wrap or stop-on-full policy.

Parameters:
- DEPTH, 1024, number of entries; power of two.
- AWID, 32, address width; matches the Address type.
- CWID, 11, width of trace_count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- cfg_en  in  1  trace enable; 0 forces the FSM to IDLE on the next edge.
- cfg_wrap  in  1  1 = overwrite oldest entry when full; 0 = freeze when full.
- cfg_trig_en  in  1  1 = wait for a trigger address before recording.
- cfg_trig_adr  in  AWID  trigger address, compared against commit_pc.
- clr  in  1  synchronous flush of pointers, count and overflow.
- commit_v  in  1  a branch instruction commits this cycle.
- commit_taken  in  1  the committing branch was taken.
- commit_pc  in  AWID  PC of the committing branch.
- commit_tgt  in  AWID  target address of the committing branch.
- pop  in  1  trace-read request from the ALU execute stage.
- trace_dout  out  AWID  popped entry.
- trace_valid  out  1  trace_dout holds data from the previous cycle's pop.
- trace_empty  out  1  count==0.
- trace_count  out  CWID  occupancy, 0..DEPTH.
- trace_ovf  out  1  sticky: an entry was dropped or overwritten.
- trace_state  out  2  current FSM state, for CSR readback.

Behaviour:
- Reset values:
  - trace_dout=0, trace_valid=0, trace_empty=1, trace_count=0, trace_ovf=0, trace_state=IDLE.
  - Pointers are 0.
  - RAM contents are undefined.
- FSM states: IDLE=0, ARMED=1, RECORD=2, FROZEN=3.
  - IDLE -> ARMED when cfg_en=1 and cfg_trig_en=1.
  - IDLE -> RECORD when cfg_en=1 and cfg_trig_en=0.
  - ARMED -> RECORD on commit_v and commit_pc==cfg_trig_adr. The triggering branch itself is recorded if it was taken.
  - RECORD -> FROZEN when a push hits full with cfg_wrap=0.
  - FROZEN is left only via clr (-> IDLE) or cfg_en=0 (-> IDLE).
  - cfg_en=0 takes every state to IDLE next edge. Buffer contents and count are retained.
- Push: push = commit_v & commit_taken & (state==RECORD, or ARMED with the trigger hitting this cycle).
  - A push writes commit_tgt at wr_ptr, then advances wr_ptr modulo DEPTH.
- Pop: a pop when count>0 reads the entry at rd_ptr and advances rd_ptr.
  - trace_dout and trace_valid are registered, so data appears one cycle after pop.
  - A pop when empty gives trace_valid=0 next cycle; trace_dout holds its previous value.
- trace_valid is a single-cycle pulse per successful pop.
- Count rules:
  - push only, not full: +1.
  - pop only, not empty: -1.
  - push and pop together, 0<count<DEPTH: unchanged.
  - push and pop with count=0: the pop is ignored (no bypass), count becomes 1, trace_valid=0.
  - push when full, cfg_wrap=1: write at wr_ptr(==rd_ptr), advance both pointers, count stays DEPTH, trace_ovf set.
  - push when full, cfg_wrap=0: entry dropped, trace_ovf set, state -> FROZEN.
  - push and pop when full, wrap mode: the RAM is read-first, so the pop returns the old oldest entry; both pointers advance, count=DEPTH, trace_ovf set.
  - push and pop when full, freeze mode: the pop succeeds, the push is dropped, trace_ovf set, FROZEN.
- clr:
  - Zeroes pointers, count and trace_ovf, and sets state to IDLE.
  - clr has priority over push and pop in the same cycle.
  - trace_valid is 0 in the cycle after clr.
- Outputs: trace_empty and trace_count come from registers (count==0), not from RAM.
- Reset mid-operation: asynchronous reset returns every output to its reset value immediately; any in-flight pop is lost.

Decomposition:
- Shared package rfPhoenixPkg gains:
  - a trace_state_t enum (IDLE, ARMED, RECORD, FROZEN);
  - a TRACE_DEPTH constant (1024);
  - Address, which is reused for entries.
- Sub-module rf_phoenix_trace_ram: simple dual-port, read-first, synchronous read, DEPTH x AWID.
  - The top level keeps the pointers, counter and FSM.

Test Plan:
- Reset, cfg_en=1, cfg_trig_en=0; three taken commits with tgt 0x100, 0x200, 0x300; then pop x3 -> trace_dout 0x100, 0x200, 0x300 on the cycles after each pop, trace_valid pulses, trace_count 3->0, trace_empty=1.
- cfg_trig_en=1, cfg_trig_adr=0x4000; taken commit at pc 0x3000 -> no push, state ARMED; taken commit at pc 0x4000 with tgt 0x5000 -> count=1, state RECORD.
- cfg_wrap=0: 1025 taken commits with tgt=n -> count=1024, trace_ovf=1, state FROZEN; first pop returns 0.
- cfg_wrap=1: 1026 commits with tgt=n -> count=1024, trace_ovf=1; pops return 2..1025.
- Full in wrap mode, simultaneous pop and push of 0xAAAA -> pop returns the old oldest entry, count stays 1024; the final entry read back is 0xAAAA.
- Empty buffer, pop and push of 0x77 together -> trace_valid=0, count=1; next pop -> 0x77. Then assert clr during a pop -> count=0, trace_valid=0, state IDLE.
